// File: rtl/branch_cmp_pkg.sv
// Shared types for the pipelined branch comparator:
// branch op codes, gt/eq/lt cascade bundle and helpers.
package branch_cmp_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_op_e;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cascade_t;

   localparam cascade_t CASCADE_EQ = 3'b010;

   function automatic logic is_signed_op(
      input logic [2:0] op
   );
      return (op == BR_BLT) || (op == BR_BGE);
   endfunction

endpackage

// File: rtl/branch_cmp_if.sv
// Handshake bundle of the branch comparator.
// slave: comparator side; master: producer/consumer side.
interface branch_cmp_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic [2:0]       i_op;
   logic [TAG_W-1:0] i_tag;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic             o_gt;
   logic             o_eq;
   logic             o_lt;
   logic             o_taken;
   logic             o_illegal;
   logic [TAG_W-1:0] o_tag;

   modport slave (
      input  i_valid, i_a, i_b, i_op, i_tag,
      input  i_flush, i_ready,
      output o_ready, o_valid, o_gt, o_eq, o_lt,
      output o_taken, o_illegal, o_tag
   );

   modport master (
      output i_valid, i_a, i_b, i_op, i_tag,
      output i_flush, i_ready,
      input  o_ready, o_valid, o_gt, o_eq, o_lt,
      input  o_taken, o_illegal, o_tag
   );
endinterface

// File: rtl/cmp_slice.sv
// One combinational compare slice: a/b slice plus
// incoming cascade in, updated cascade out.
module cmp_slice
   import branch_cmp_pkg::*;
#(
   parameter int STAGE_BITS = 8
) (
   input  logic [STAGE_BITS-1:0] a,
   input  logic [STAGE_BITS-1:0] b,
   input  cascade_t              cin,
   output cascade_t              cout
);

   // A decided relation from a more significant
   // slice wins; only an equal prefix looks here.
   always_comb begin
      cout = cin;
      if (cin.eq) begin
         cout.gt = (a > b);
         cout.eq = (a == b);
         cout.lt = (a < b);
      end
   end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined MSB-first magnitude compare + branch decision.
// Ports: i_clk, i_rst_n, bus (branch_cmp_if.slave).
module branch_cmp_pipe
   import branch_cmp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int STAGE_BITS = 8,
   parameter int TAG_W      = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   branch_cmp_if.slave  bus
);

   localparam int L = WIDTH / STAGE_BITS;

   if (STAGE_BITS < 1 || (WIDTH % STAGE_BITS) != 0) begin : g_bad
      $error("WIDTH must be a multiple of STAGE_BITS");
   end

   logic [L-1:0]     v_q;
   logic [L-1:0]     v_in;
   logic [L-1:0]     ld;
   cascade_t         cas_q  [L];
   cascade_t         cas_in [L];
   cascade_t         cas_d  [L];
   logic [WIDTH-1:0] a_q    [L];
   logic [WIDTH-1:0] b_q    [L];
   logic [WIDTH-1:0] a_in   [L];
   logic [WIDTH-1:0] b_in   [L];
   logic [2:0]       op_q   [L];
   logic [2:0]       op_in  [L];
   logic [TAG_W-1:0] tag_q  [L];
   logic [TAG_W-1:0] tag_in [L];
   logic [WIDTH-1:0] flip;
   cascade_t         res;
   logic             taken;
   logic             illegal;

   // Inverting both sign bits maps signed order
   // onto unsigned order.
   always_comb begin
      flip      = WIDTH'(is_signed_op(bus.i_op)) << (WIDTH - 1);
      v_in[0]   = bus.i_valid;
      a_in[0]   = bus.i_a ^ flip;
      b_in[0]   = bus.i_b ^ flip;
      op_in[0]  = bus.i_op;
      tag_in[0] = bus.i_tag;
      cas_in[0] = CASCADE_EQ;
      for (int k = 1; k < L; k++) begin
         v_in[k]   = v_q[k-1];
         a_in[k]   = a_q[k-1];
         b_in[k]   = b_q[k-1];
         op_in[k]  = op_q[k-1];
         tag_in[k] = tag_q[k-1];
         cas_in[k] = cas_q[k-1];
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_slice
      cmp_slice #(
         .STAGE_BITS (STAGE_BITS)
      ) u_slice (
         .a    (a_in[k][WIDTH-1 -: STAGE_BITS]),
         .b    (b_in[k][WIDTH-1 -: STAGE_BITS]),
         .cin  (cas_in[k]),
         .cout (cas_d[k])
      );
   end

   assign bus.o_valid = v_q[L-1] & ~bus.i_flush;

   // Ready ripples back from the consumer so empty
   // slots ahead of a stall get filled.
   always_comb begin
      ld      = '0;
      ld[L-1] = ~v_q[L-1] | (bus.o_valid & bus.i_ready);
      for (int k = L - 2; k >= 0; k--) begin
         ld[k] = ~v_q[k] | ld[k+1];
      end
   end

   assign bus.o_ready = ld[0];

   // Operands shift left so the next slice to
   // compare always sits at the top bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < L; k++) begin
            v_q[k]   <= 1'b0;
            cas_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            op_q[k]  <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < L; k++) begin
            if (bus.i_flush) begin
               v_q[k] <= 1'b0;
            end else if (ld[k]) begin
               v_q[k] <= v_in[k];
               if (v_in[k]) begin
                  cas_q[k] <= cas_d[k];
                  a_q[k]   <= a_in[k] << STAGE_BITS;
                  b_q[k]   <= b_in[k] << STAGE_BITS;
                  op_q[k]  <= op_in[k];
                  tag_q[k] <= tag_in[k];
               end
            end
         end
      end
   end

   always_comb begin
      res     = cas_q[L-1];
      taken   = 1'b0;
      illegal = 1'b0;
      unique case (op_q[L-1])
         BR_BEQ:  taken = res.eq;
         BR_BNE:  taken = ~res.eq;
         BR_BLT,
         BR_BLTU: taken = res.lt;
         BR_BGE,
         BR_BGEU: taken = res.gt | res.eq;
         default: illegal = 1'b1;
      endcase
   end

   assign bus.o_gt      = res.gt;
   assign bus.o_eq      = res.eq;
   assign bus.o_lt      = res.lt;
   assign bus.o_taken   = taken;
   assign bus.o_illegal = illegal;
   assign bus.o_tag     = tag_q[L-1];

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Scoreboard bench for branch_cmp_pipe (WIDTH 32,
// STAGE_BITS 8, latency 4).
module tb_branch_cmp_pipe;
   import branch_cmp_pkg::*;

   localparam int W     = 32;
   localparam int SB    = 8;
   localparam int TW    = 4;
   localparam int L     = 4;
   localparam int BOUND = 50;

   typedef struct {
      logic [8:0] res;
      int         acc;
      bit         lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];

   branch_cmp_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   branch_cmp_pipe #(
      .WIDTH      (W),
      .STAGE_BITS (SB),
      .TAG_W      (TW)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h",
                  name, act, req);
      end
   endtask

   function automatic logic [9:0] snap();
      return {bus.o_valid, bus.o_gt, bus.o_eq, bus.o_lt,
              bus.o_taken, bus.o_illegal, bus.o_tag};
   endfunction

   // Monitor: pops one expectation per consumed result.
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual tag=%0d required none",
                     bus.o_tag);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", 32'({bus.o_gt, bus.o_eq, bus.o_lt,
                               bus.o_taken, bus.o_illegal,
                               bus.o_tag}), 32'(e.res));
            if (e.lat) chk("latency", cyc - e.acc, L);
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 after accept.
   // flags = {gt, eq, lt, taken, illegal}
   task automatic send(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [2:0]  op,
                       input logic [3:0]  tag,
                       input logic [4:0]  flags,
                       input bit          push,
                       input bit          lat,
                       input bit          flush);
      int n;
      n = 0;
      bus.i_a     = a;
      bus.i_b     = b;
      bus.i_op    = op;
      bus.i_tag   = tag;
      bus.i_valid = 1'b1;
      bus.i_flush = flush;
      @(negedge clk);
      while (!bus.o_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=busy required=ready");
      end else if (push) begin
         exp_t e;
         e.res = {flags, tag};
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #2;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      @(posedge clk);
      #2;
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk("no_valid", bus.o_valid, 0);
      end
      @(posedge clk);
      #2;
   endtask

   logic [31:0] va [11] = '{32'h0000_0001, 32'h0000_0001,
      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000,
      32'h1234_5679, 32'h0000_0005, 32'h0000_0003,
      32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
   logic [31:0] vb [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0001,
      32'h1234_5678, 32'h0000_0003, 32'h0000_0005,
      32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
   logic [2:0]  vop [11] = '{3'b110, 3'b100, 3'b000,
      3'b001, 3'b101, 3'b111, 3'b010, 3'b011,
      3'b100, 3'b101, 3'b110};
   logic [4:0]  vfl [11] = '{5'b00110, 5'b10000, 5'b01010,
      5'b01000, 5'b00100, 5'b10010, 5'b10001, 5'b00101,
      5'b00110, 5'b10010, 5'b10000};

   logic [9:0] held;

   initial begin
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_op    = '0;
      bus.i_tag   = '0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b1;
      #1;
      chk("reset_valid", bus.o_valid, 0);
      chk("reset_ready", bus.o_ready, 1);
      chk("reset_outs", 32'(snap()), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Directed vectors, back to back.
      for (int i = 0; i < 11; i++)
         send(va[i], vb[i], vop[i], 4'(i), vfl[i], 1, 1, 0);
      drain();

      // Eight consecutive ops, tags 0..7, BEQ a=i vs b=3.
      for (int i = 0; i < 8; i++)
         send(32'(i), 32'd3, 3'b000, 4'(i),
              (i < 3) ? 5'b00100 :
              (i == 3) ? 5'b01010 : 5'b10000, 1, 1, 0);
      drain();

      // Fill the pipe with the consumer stalled.
      bus.i_ready = 1'b0;
      for (int i = 8; i < 12; i++)
         send(32'(i), 32'd10, 3'b110, 4'(i),
              (i < 10) ? 5'b00110 :
              (i == 10) ? 5'b01000 : 5'b10000, 1, 0, 0);
      @(negedge clk);
      held = snap();
      chk("stall_ready", bus.o_ready, 0);
      chk("stall_valid", bus.o_valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", bus.o_ready, 0);
         chk("stall_hold", 32'(snap()), 32'(held));
      end
      @(posedge clk);
      #2;
      bus.i_ready = 1'b1;
      drain();

      // Flush with three in flight plus a same-cycle accept.
      for (int i = 12; i < 15; i++)
         send(32'd1, 32'd1, 3'b000, 4'(i), 5'b01010, 0, 0, 0);
      send(32'd1, 32'd1, 3'b000, 4'd15, 5'b01010, 0, 0, 1);
      idle_check(6);
      send(32'd7, 32'd7, 3'b000, 4'd15, 5'b01010, 1, 1, 0);
      drain();

      // Reset while a result is waiting at the output.
      bus.i_ready = 1'b0;
      send(32'd1, 32'd2, 3'b001, 4'd2, 5'b00110, 0, 0, 0);
      send(32'd1, 32'd2, 3'b001, 4'd3, 5'b00110, 0, 0, 0);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      chk("pre_reset_valid", bus.o_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_valid", bus.o_valid, 0);
      chk("mid_reset_ready", bus.o_ready, 1);
      chk("mid_reset_tag", bus.o_tag, 0);
      bus.i_ready = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle_check(6);
      send(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, 4'd9,
           5'b00110, 1, 1, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
